// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction-memory handshake and instruction-register link of the control sequencer.
interface ctrl_sequencer_if;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;
    logic        en_ir;
    logic        ir_valid;
    logic [15:0] ir_out;
    modport master (output mem_rd, mem_wr, en_ir, input mem_ready, ir_valid, ir_out);
    modport slave (input mem_rd, mem_wr, en_ir, output mem_ready, ir_valid, ir_out);
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/execute control FSM with memory-wait timeout and retired-instruction count.
module ctrl_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             zero_flag,
    ctrl_sequencer_if.master bus,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             alu_en,
    output logic             reg_wr,
    output logic             illegal,
    output logic             bus_err,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, LOAD_IR = 4'd2, WAIT_IR = 4'd3, DECODE = 4'd4,
        EXEC = 4'd5, MEM = 4'd6, WB = 4'd7, HALT = 4'd8
    } state_t;
    localparam int WW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_t cur, nxt;
    logic [WW-1:0] wcnt;
    logic is_st, retire;
    logic [3:0] op;
    logic waiting, timeout;
    assign op      = bus.ir_out[15:12];
    assign state   = cur;
    assign waiting = (cur == FETCH || cur == MEM) && !bus.mem_ready;
    assign timeout = TIMEOUT != 0 && waiting && wcnt == WLAST;
    always_comb begin
        nxt        = cur;
        retire     = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.en_ir  = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_en     = 1'b0;
        reg_wr     = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (cur)
            IDLE: nxt = start ? FETCH : IDLE;
            FETCH: begin
                bus.mem_rd = 1'b1;
                nxt = bus.mem_ready ? LOAD_IR : timeout ? HALT : FETCH;
            end
            LOAD_IR: begin
                bus.en_ir = 1'b1;
                pc_inc    = 1'b1;
                nxt       = WAIT_IR;
            end
            WAIT_IR: nxt = bus.ir_valid ? DECODE : WAIT_IR;
            DECODE: begin
                // NOP, jumps, branches and undefined opcodes all retire here
                nxt    = FETCH;
                retire = 1'b1;
                case (op)
                    4'h0: nxt = FETCH;
                    4'h1, 4'h2, 4'h3, 4'h4: begin
                        nxt    = EXEC;
                        retire = 1'b0;
                    end
                    4'h5, 4'h6: begin
                        nxt    = MEM;
                        retire = 1'b0;
                    end
                    4'h7: pc_load = 1'b1;
                    4'h8: pc_load = zero_flag;
                    4'hF: nxt = HALT;
                    default: illegal = 1'b1;
                endcase
            end
            EXEC: begin
                alu_en = 1'b1;
                nxt    = WB;
            end
            MEM: begin
                bus.mem_rd = !is_st;
                bus.mem_wr = is_st;
                retire     = bus.mem_ready && is_st;
                nxt = bus.mem_ready ? (is_st ? FETCH : WB) : timeout ? HALT : MEM;
            end
            WB: begin
                reg_wr = 1'b1;
                retire = 1'b1;
                nxt    = FETCH;
            end
            HALT: halted = 1'b1;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur       <= IDLE;
            wcnt      <= '0;
            instr_cnt <= '0;
            bus_err   <= 1'b0;
            is_st     <= 1'b0;
        end else begin
            cur       <= nxt;
            wcnt      <= (nxt != cur) ? '0 : waiting ? wcnt + 1'b1 : wcnt;
            instr_cnt <= instr_cnt + CNT_W'(retire);
            bus_err   <= bus_err | timeout;
            if (cur == DECODE) is_st <= op == 4'h6;
        end
    end
endmodule
